// File: rtl/sync_fifo_wr_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_wr_arb_pkg
// Description : Shared definitions for the sync_fifo write-port arbiter.
//               Holds the arbiter state encoding and the helpers that size
//               the owner index and the beat counter.
// Revision    : 1.0 - initial release
// ============================================================================
package sync_fifo_wr_arb_pkg;

  // Arbiter states. The encoding is fixed so that busy is simply the state bit.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  // Width of a requester index. A single requester still gets one bit so
  // that no zero-width vectors appear anywhere.
  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width of the beat counter. It has to hold MAX_BURST itself, because the
  // counter is bumped on the beat that forces the release.
  function automatic int cnt_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage : sync_fifo_wr_arb_pkg
`default_nettype wire

// File: rtl/sync_fifo_wr_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin selector. Scans the request vector
//               starting just after the previous winner and returns the first
//               requester found, wrapping modulo NUM_REQ.
// Ports       : req_i          - request vector, one bit per requester
//               last_winner_i  - index of the previous winner
//               pick_o         - index of the selected requester
//               any_valid_o    - at least one request is present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    last_winner_i,
  output logic [ID_W-1:0]    pick_o,
  output logic               any_valid_o
);

  int w_idx;

  // Walk the candidates from furthest to nearest so that the last hit, which
  // is the one closest after last_winner, is the one that sticks.
  always_comb begin
    pick_o      = '0;
    any_valid_o = 1'b0;
    w_idx       = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = (int'(last_winner_i) + k) % NUM_REQ;
      if (req_i[w_idx[ID_W-1:0]]) begin
        pick_o      = w_idx[ID_W-1:0];
        any_valid_o = 1'b1;
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/sync_fifo_wr_arb.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_wr_arb
// Description : Round-robin burst arbiter sharing the single write port of
//               sync_fifo among NUM_REQ requesters. The winning requester keeps
//               the grant for a whole burst (up to MAX_BURST beats). A beat is
//               only accepted while the FIFO has room beyond the write already
//               in flight, so fifo_wren never lands on a full FIFO.
// Ports       : clk, rst          - clock (rising edge), async active-high reset
//               req_valid/last    - per-requester beat valid / last beat
//               req_data          - flattened beats, requester i at
//                                   [i*FIFO_DATA +: FIFO_DATA]
//               req_ready         - beat accepted this cycle (one-hot or 0)
//               fifo_room_avail   - free entries reported by sync_fifo
//               fifo_wren/wdata   - registered write port into sync_fifo
//               grant_id          - current / most recent owner
//               busy              - high while a burst is owned
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_wr_arb
  import sync_fifo_wr_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int FIFO_DATA = 32,
  parameter int FIFO_PTR  = 4,
  parameter int MAX_BURST = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_last,
  input  logic [NUM_REQ*FIFO_DATA-1:0]    req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [FIFO_PTR:0]               fifo_room_avail,
  output logic                            fifo_wren,
  output logic [FIFO_DATA-1:0]            fifo_wdata,
  output logic [id_width(NUM_REQ)-1:0]    grant_id,
  output logic                            busy
);

  localparam int ID_W  = id_width(NUM_REQ);
  localparam int CNT_W = cnt_width(MAX_BURST);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  arb_state_e            state_q,       state_d;
  logic [ID_W-1:0]       grant_id_q,    grant_id_d;     // doubles as the owner
  logic [ID_W-1:0]       last_winner_q, last_winner_d;
  logic [CNT_W-1:0]      beat_cnt_q,    beat_cnt_d;
  logic                  fifo_wren_q,   fifo_wren_d;
  logic [FIFO_DATA-1:0]  fifo_wdata_q,  fifo_wdata_d;

  // --------------------------------------------------------------------------
  // Per-requester views of the flattened data bus
  // --------------------------------------------------------------------------
  logic [FIFO_DATA-1:0]  w_req_data [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_req_data[gi] = req_data[gi*FIFO_DATA +: FIFO_DATA];
  end

  // --------------------------------------------------------------------------
  // Round-robin selection
  // --------------------------------------------------------------------------
  logic [ID_W-1:0] w_pick;
  logic            w_any_valid;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req_i         (req_valid),
    .last_winner_i (last_winner_q),
    .pick_o        (w_pick),
    .any_valid_o   (w_any_valid)
  );

  // --------------------------------------------------------------------------
  // Owner signals and flow control
  // --------------------------------------------------------------------------
  logic                 w_owner_valid;
  logic                 w_owner_last;
  logic [FIFO_DATA-1:0] w_owner_data;
  logic                 w_space_ok;
  logic                 w_accept;
  logic                 w_burst_full;

  assign w_owner_valid = req_valid[grant_id_q];
  assign w_owner_last  = req_last[grant_id_q];
  assign w_owner_data  = w_req_data[grant_id_q];

  // room_avail does not yet account for the registered write still in flight,
  // so one extra free slot is required while fifo_wren is high.
  assign w_space_ok    = fifo_room_avail > {{FIFO_PTR{1'b0}}, fifo_wren_q};

  // The beat being accepted now is the last one this grant may carry.
  assign w_burst_full  = (beat_cnt_q == CNT_W'(MAX_BURST - 1));

  // --------------------------------------------------------------------------
  // Next-state / output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    last_winner_d = last_winner_q;
    beat_cnt_d    = beat_cnt_q;
    fifo_wren_d   = 1'b0;
    fifo_wdata_d  = fifo_wdata_q;
    req_ready     = '0;
    w_accept      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Arbitration costs one bubble cycle: no beat is taken in IDLE.
        if (w_any_valid) begin
          grant_id_d = w_pick;
          beat_cnt_d = '0;
          state_d    = ST_BURST;
        end
      end

      ST_BURST: begin
        req_ready[grant_id_q] = w_owner_valid & w_space_ok;
        w_accept              = w_owner_valid & w_space_ok;

        if (w_accept) begin
          fifo_wren_d  = 1'b1;
          fifo_wdata_d = w_owner_data;
          beat_cnt_d   = beat_cnt_q + CNT_W'(1);
          if (w_owner_last || w_burst_full) begin
            last_winner_d = grant_id_q;
            state_d       = ST_IDLE;
          end
        end else if (!w_owner_valid) begin
          // Owner walked away mid-burst: release without writing anything.
          last_winner_d = grant_id_q;
          state_d       = ST_IDLE;
        end
        // Valid but no space: hold the grant and stall.
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      grant_id_q    <= '0;
      // Starting from the highest index makes requester 0 the first winner.
      last_winner_q <= ID_W'(NUM_REQ - 1);
      beat_cnt_q    <= '0;
      fifo_wren_q   <= 1'b0;
      fifo_wdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      grant_id_q    <= grant_id_d;
      last_winner_q <= last_winner_d;
      beat_cnt_q    <= beat_cnt_d;
      fifo_wren_q   <= fifo_wren_d;
      fifo_wdata_q  <= fifo_wdata_d;
    end
  end

  assign fifo_wren  = fifo_wren_q;
  assign fifo_wdata = fifo_wdata_q;
  assign grant_id   = grant_id_q;
  assign busy       = (state_q == ST_BURST);

endmodule : sync_fifo_wr_arb
`default_nettype wire

// File: tb/tb_sync_fifo_wr_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_wr_arb
// Description : Self-checking bench for sync_fifo_wr_arb. A behavioural model
//               (owner index, beat count, last winner, one-cycle write delay)
//               predicts every output each cycle; directed scenarios pin the
//               model with hand-computed values, then random traffic runs
//               against a 16-deep FIFO occupancy model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_wr_arb;

  localparam int N     = 4;
  localparam int FD    = 32;
  localparam int FP    = 4;
  localparam int MB    = 8;
  localparam int IDW   = 2;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_last;
  logic [N*FD-1:0]  req_data;
  logic [N-1:0]     req_ready;
  logic [FP:0]      room;
  logic             fifo_wren;
  logic [FD-1:0]    fifo_wdata;
  logic [IDW-1:0]   grant_id;
  logic             busy;

  always #5 clk = ~clk;

  sync_fifo_wr_arb #(
    .NUM_REQ   (N),
    .FIFO_DATA (FD),
    .FIFO_PTR  (FP),
    .MAX_BURST (MB)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_last        (req_last),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .fifo_room_avail (room),
    .fifo_wren       (fifo_wren),
    .fifo_wdata      (fifo_wdata),
    .grant_id        (grant_id),
    .busy            (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: m_owner = -1 means nobody owns the port.
  int          m_owner;
  int          m_beats;
  int          m_lw;
  int          m_grant;
  bit          m_wren;
  logic [FD-1:0] m_wdata;
  logic [N-1:0]  m_ready;

  // Environment: FIFO occupancy and requester burst bookkeeping.
  int  fcnt;
  bit  do_rd;
  int  room_force;
  int  wr_pulses;
  bit  rnd_mode;
  int  rem      [N];
  int  restart  [N];
  bit  use_last [N];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    r = '0;
    if (m_owner >= 0 && req_valid[m_owner] && int'(room) > (m_wren ? 1 : 0))
      r[m_owner] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_beats = 0;
    m_lw    = N - 1;
    m_grant = 0;
    m_wren  = 1'b0;
    m_wdata = '0;
    fcnt    = 0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"}, req_ready, 0);
    chk({tag, "_wren"},  fifo_wren, 0);
    chk({tag, "_wdata"}, fifo_wdata, 0);
    chk({tag, "_grant"}, grant_id, 0);
    chk({tag, "_busy"},  busy, 0);
  endtask

  task automatic kick(input int i, input int n, input bit ul);
    rem[i]      = n;
    use_last[i] = ul;
    req_valid[i] = 1'b1;
    req_last[i]  = ul && (n == 1);
    req_data[i*FD +: FD] = $urandom;
  endtask

  task automatic drop(input int i);
    rem[i]       = 0;
    req_valid[i] = 1'b0;
    req_last[i]  = 1'b0;
  endtask

  task automatic set_room();
    room = (room_force >= 0) ? (FP+1)'(room_force) : (FP+1)'(DEPTH - fcnt);
  endtask

  // One clock cycle: compare at the falling edge, advance the model and the
  // FIFO occupancy at the rising edge, then update requesters 1 ns later.
  task automatic step();
    logic [N-1:0]    cv, cl, cacc, cready;
    logic [N*FD-1:0] cd;
    bit              cw, rd, acc, found;
    int              idx;
    @(negedge clk);
    m_ready = exp_ready();
    chk("req_ready",  req_ready,  m_ready);
    chk("fifo_wren",  fifo_wren,  m_wren);
    chk("fifo_wdata", fifo_wdata, m_wdata);
    chk("grant_id",   grant_id,   m_grant);
    chk("busy",       busy,       (m_owner >= 0));
    chk("no_write_when_full", (fifo_wren && fcnt >= DEPTH), 0);
    cv = req_valid; cl = req_last; cd = req_data; cw = fifo_wren;
    cacc = req_valid & req_ready; cready = m_ready;
    rd = do_rd && (fcnt > 0);
    @(posedge clk);
    fcnt = fcnt + (cw ? 1 : 0) - (rd ? 1 : 0);
    if (cw) wr_pulses++;
    if (m_owner < 0) begin
      m_wren = 1'b0;
      found  = 1'b0;
      for (int k = 1; k <= N; k++) begin
        idx = (m_lw + k) % N;
        if (!found && cv[idx]) begin
          found   = 1'b1;
          m_owner = idx;
          m_grant = idx;
          m_beats = 0;
        end
      end
    end else begin
      acc = cv[m_owner] && cready[m_owner];
      if (acc) begin
        m_wren  = 1'b1;
        m_wdata = cd[m_owner*FD +: FD];
        m_beats++;
        if (cl[m_owner] || m_beats == MB) begin
          m_lw    = m_owner;
          m_owner = -1;
        end
      end else begin
        m_wren = 1'b0;
        if (!cv[m_owner]) begin
          m_lw    = m_owner;
          m_owner = -1;
        end
      end
    end
    #1;
    for (int i = 0; i < N; i++) begin
      if (cacc[i]) begin
        rem[i]--;
        if (rem[i] == 0 && restart[i] > 0) rem[i] = restart[i];
      end
      if (rnd_mode) begin
        if (rem[i] > 0 && req_valid[i] && !cacc[i] && $urandom_range(0, 49) == 0)
          rem[i] = 0;
        else if (rem[i] == 0 && !req_valid[i] && $urandom_range(0, 3) == 0) begin
          rem[i]      = int'($urandom_range(1, 12));
          use_last[i] = 1'b1;
        end
      end
      if (rem[i] > 0) begin
        if (cacc[i] || !req_valid[i]) begin
          req_data[i*FD +: FD] = $urandom;
          req_last[i]          = use_last[i] && (rem[i] == 1);
        end
        req_valid[i] = 1'b1;
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
      end
    end
    set_room();
  endtask

  int t2_seq [5] = '{0, 1, 2, 3, 0};
  int wp;

  initial begin
    rst = 1'b1;
    req_valid = '0; req_last = '0; req_data = '0;
    do_rd = 1'b1; room_force = -1; wr_pulses = 0; rnd_mode = 1'b0;
    for (int i = 0; i < N; i++) begin rem[i] = 0; restart[i] = 0; use_last[i] = 1'b1; end
    model_reset();
    set_room();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("reset");
    rst = 1'b0;

    // Fairness: everybody always has a one-beat burst waiting.
    for (int i = 0; i < N; i++) begin restart[i] = 1; kick(i, 1, 1'b1); end
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t2_grant", grant_id, t2_seq[k]);
      step();
      chk("t2_bubble", busy, 0);
    end
    for (int i = 0; i < N; i++) begin restart[i] = 0; drop(i); end

    // Forced release: requester 2 never sends last, requester 3 waits.
    kick(2, 20, 1'b0);
    kick(3, 1, 1'b1);
    step();
    wp = wr_pulses;
    repeat (8) step();
    chk("t3_idle_after_8", busy, 0);
    step();
    chk("t3_writes", wr_pulses - wp, 8);
    chk("t3_next_grant", grant_id, 3);

    // Abandon: requester 2 is granted again, then drops valid before last.
    step();
    step();
    chk("t6_grant", grant_id, 2);
    wp = wr_pulses;
    drop(2);
    kick(0, 1, 1'b1);
    step();
    step();
    chk("t6_next_grant", grant_id, 0);
    chk("t6_no_write", wr_pulses - wp, 0);

    // Backpressure with room_avail pinned at 1.
    room_force = 1;
    set_room();
    kick(1, 3, 1'b1);
    step();
    step();
    step();
    chk("t4_stall", req_ready, 4'b0000);
    step();
    chk("t4_resume", req_ready, 4'b0010);
    room_force = -1;
    set_room();
    repeat (6) step();

    // Full FIFO: no reads, one long stream from requester 0.
    repeat (20) step();
    do_rd = 1'b0;
    wp = wr_pulses;
    kick(0, 40, 1'b0);
    repeat (45) step();
    chk("t5_writes", wr_pulses - wp, DEPTH);
    chk("t5_full", fcnt, DEPTH);
    chk("t5_stall_ready", req_ready, 4'b0000);
    chk("t5_stall_busy", busy, 1);
    drop(0);
    do_rd = 1'b1;
    repeat (20) step();

    // Reset mid-burst: requester 1 is on beat 2 of 4.
    kick(1, 4, 1'b1);
    repeat (3) step();
    chk("t1_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    chk_reset_outs("t1_async");
    model_reset();
    set_room();
    @(posedge clk);
    #1;
    chk_reset_outs("t1_edge");
    @(posedge clk);
    #1;
    rst = 1'b0;
    kick(0, 1, 1'b1);
    step();
    chk("t1_first_grant", grant_id, 0);
    drop(0);
    drop(1);
    repeat (4) step();

    // Random traffic.
    rnd_mode = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      do_rd = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_sync_fifo_wr_arb
`default_nettype wire
